// File: rtl/fsqrt_wb_queue.sv
// Tag delay line and credit-gated result FIFO behind the
// fixed-latency, non-stallable square-root pipeline.
module fsqrt_wb_queue #(
  parameter int LATENCY = 5,
  parameter int TAGW    = 6,
  parameter int DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  input  logic [31:0]     sq_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [31:0]     out_data,
  output logic            err_ovf
);

  localparam int IW = $clog2(LATENCY + 1) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  logic [LATENCY-1:0] v_q, v_d;
  logic [TAGW-1:0]    t_q [LATENCY];
  logic [TAGW-1:0]    t_d [LATENCY];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      inf_q, inf_d;
  logic               err_q, err_d;
  logic [TAGW+31:0]   mem [DEPTH];

  logic acc, arr, pop, push, full;
  logic [SW-1:0] credit;

  // Credit covers both queued and in-flight ops so arrivals always fit.
  assign credit   = SW'(inf_q) + SW'(cnt_q);
  assign in_ready = credit < SW'(DEPTH);
  assign full     = cnt_q == CW'(DEPTH);

  assign acc  = in_valid & in_ready & ~flush;
  assign arr  = v_q[LATENCY-1] & ~flush;
  assign pop  = out_valid & out_ready;
  assign push = arr & (~full | pop);

  assign out_valid = cnt_q != '0;
  assign out_tag   = out_valid ? mem[rd_q][TAGW+31:32] : '0;
  assign out_data  = out_valid ? mem[rd_q][31:0] : '0;
  assign err_ovf   = err_q;

  always_comb begin
    v_d    = {v_q[LATENCY-2:0], acc};
    t_d[0] = in_tag;
    for (int k = 1; k < LATENCY; k++) begin
      t_d[k] = t_q[k-1];
    end
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    inf_d = inf_q + IW'(acc) - IW'(arr);
    err_d = err_q | (arr & full & ~pop);
    if (flush) begin
      v_d   = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      inf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      inf_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        t_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      inf_q <= inf_d;
      err_q <= err_d;
      for (int k = 0; k < LATENCY; k++) begin
        t_q[k] <= t_d[k];
      end
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= {t_q[LATENCY-1], sq_y};
    end
  end

endmodule

// File: tb/tb_fsqrt_wb_queue.sv
// Bench for fsqrt_wb_queue: sqrt pipe stand-in, queue-based
// reference model checked every cycle, plus directed scenarios.
module tb_fsqrt_wb_queue;

  localparam int LAT = 5;
  localparam int TW  = 6;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic [31:0]   sq_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_tag;
  logic [31:0]   out_data;
  logic          err_ovf;
  logic [31:0]   x = '0;

  int tests = 0;
  int fails = 0;

  fsqrt_wb_queue #(.LATENCY(LAT), .TAGW(TW), .DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .flush(flush), .sq_y(sq_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Stand-in sqrt: exact for a few known operands, a hash otherwise.
  function automatic logic [31:0] sqfn(input logic [31:0] a);
    case (a)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h00000000: return 32'h00000000;
      default:      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  logic [31:0] xp [LAT];
  always @(posedge clk) begin
    xp[0] <= x;
    for (int k = 1; k < LAT; k++) xp[k] <= xp[k-1];
  end
  assign sq_y = sqfn(xp[LAT-1]);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ops in flight carry their due cycle.
  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
    int            due;
  } item_t;

  item_t infl[$];
  item_t mf[$];
  item_t it;
  bit    m_err;
  bit    m_rdy, m_pop, m_acc, m_arr;
  int    cyc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      infl.delete();
      mf.delete();
      m_err = 1'b0;
      cyc = 0;
    end else begin
      cyc++;
      m_rdy = (infl.size() + mf.size()) < DEP;
      m_pop = (mf.size() != 0) && out_ready;
      m_acc = in_valid && m_rdy && !flush;
      if (flush) begin
        infl.delete();
        mf.delete();
      end else begin
        m_arr = (infl.size() != 0) && (infl[0].due == cyc);
        if (m_pop) void'(mf.pop_front());
        if (m_arr) begin
          it = infl.pop_front();
          if (mf.size() >= DEP) m_err = 1'b1;
          else mf.push_back(it);
        end
        if (m_acc) begin
          it.tag = in_tag;
          it.data = sqfn(x);
          it.due = cyc + LAT;
          infl.push_back(it);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", 64'(out_valid), 64'(mf.size() != 0));
    chk("m_ready", 64'(in_ready),
        64'((infl.size() + mf.size()) < DEP));
    chk("m_tag", 64'(out_tag), 64'((mf.size() != 0) ? mf[0].tag : '0));
    chk("m_data", 64'(out_data),
        64'((mf.size() != 0) ? mf[0].data : 32'h0));
    chk("m_err", 64'(err_ovf), 64'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wait(input logic [TW-1:0] tg, input logic [31:0] xv,
                            input logic [31:0] ed, input string nm);
    int n, first, vc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_tag = tg;
    x = xv;
    chk({nm, "_rdy"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    n = 1;
    first = 0;
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        vc++;
        if (first == 0) begin
          first = n;
          chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
          chk({nm, "_data"}, 64'(out_data), 64'(ed));
        end
      end
      step();
      n++;
    end
    chk({nm, "_lat"}, 64'(first), 64'(6));
    chk({nm, "_len"}, 64'(vc), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no summary after time limit");
    $fatal(1);
  end

  initial begin
    int acc_n, seen;
    int tagc;
    logic [TW-1:0] got[$];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_tag", 64'(out_tag), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_err", 64'(err_ovf), 64'(0));
    rstn = 1'b1;
    step();

    issue_wait(6'h15, 32'h40800000, 32'h40000000, "single");

    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_tag = TW'(i);
      x = 32'h1000 + i;
      if (in_ready) acc_n++;
      if (i == 8) chk("fill_rdy8", 64'(in_ready), 64'(0));
      step();
    end
    in_valid = 1'b0;
    chk("fill_acc", 64'(acc_n), 64'(8));
    repeat (6) step();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) got.push_back(out_tag);
      step();
    end
    chk("drain_n", 64'(got.size()), 64'(8));
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("drain_ord", 64'(got[i]), 64'(i));
    chk("drain_rdy", 64'(in_ready), 64'(1));
    chk("drain_err", 64'(err_ovf), 64'(0));

    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_tag = TW'(i);
      x = 32'h41100000;
      step();
    end
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rdy", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("flush_none", 64'(seen), 64'(0));
    issue_wait(6'h04, 32'h41100000, 32'h40400000, "post_flush");

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_tag = TW'(10 + i);
      x = 32'h2000 + i;
      step();
    end
    in_valid = 1'b0;
    repeat (7) step();
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_rdy", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("post_rst_none", 64'(seen), 64'(0));

    issue_wait(6'h3F, 32'h00000000, 32'h00000000, "zero");

    tagc = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      x = $urandom;
      in_tag = TW'(tagc);
      if (in_valid && in_ready) tagc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("rand_empty", 64'(out_valid), 64'(0));
    chk("rand_err", 64'(err_ovf), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsqrt_wb_queue.md
Name: fsqrt_wb_queue

Overview:
- Downstream companion of the fixed-latency, non-stallable square-root pipeline. It sits between the FPU issue logic and the register-file writeback arbiter.
- It carries a destination tag alongside each operand while the operand is in the sqrt pipe. It pairs the tag with the sqrt result when that result emerges.
- Results are buffered in a small FIFO so the writeback arbiter can back-pressure with valid/ready.
- Credit-based issue gating ensures a result leaving the non-stallable pipe always has a FIFO slot.

Parameters:
- LATENCY, 5, cycles from operand presented at sqrt input to matching result on sqrt output (must equal sqrt NSTAGE).
- TAGW, 6, destination tag width.
- DEPTH, 8, result FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  issue request; operand is driven to the sqrt x input in the same cycle.
- in_ready  out  1  block can accept an issue this cycle.
- in_tag  in  TAGW  destination tag of the issued op.
- flush  in  1  synchronous kill of all in-flight and queued ops.
- sq_y  in  32  sqrt pipeline output y.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  writeback arbiter accepts head.
- out_tag  out  TAGW  head tag.
- out_data  out  32  head result.
- err_ovf  out  1  sticky: arrival while FIFO full (must never fire).

Behaviour:
- Reset (async, rstn=0): delay-line valids=0, FIFO empty (rd/wr ptr=0, count=0), inflight=0, err_ovf=0. Outputs: out_valid=0, in_ready=1, out_tag/out_data=0.
- Accept: acc = in_valid & in_ready & ~flush.
- Delay line: LATENCY-stage shift register of {valid, tag}. Stage0 <= {acc, in_tag}; stage k <= stage k-1.
- Arrival: arr = stage[LATENCY-1].valid & ~flush. Result data is sq_y sampled in that same cycle, i.e. exactly LATENCY cycles after acc.
- inflight counter, width clog2(LATENCY+1)+1: +1 on acc, -1 on arr, net 0 when both occur.
- in_ready = (inflight + count) < DEPTH, combinational from registered state only (no path from in_valid or out_ready).
- FIFO write on arr: {stage tag, sq_y} at wr ptr, ptr wraps modulo DEPTH.
- FIFO read on out_valid & out_ready: rd ptr advances with wrap.
- Simultaneous push and pop: count unchanged. Push and pop on a full FIFO are legal only when a pop occurs that cycle.
- out_valid = (count != 0). out_tag/out_data show the head combinationally from the storage array.
- Ordering: strictly in-order. Tags are never reordered or duplicated.
- err_ovf is set when arr and count==DEPTH with no pop. The entry is dropped and err_ovf stays 1 until reset. The credit rule makes this unreachable.
- flush=1 (synchronous): at the next edge all delay-line valids=0, FIFO emptied, inflight=0. Any sqrt results arriving in the flush cycle are discarded. in_ready returns to 1 the cycle after flush. A new issue is accepted the cycle after flush deasserts. The sqrt datapath itself is not reset; its stale outputs are ignored because the valids are cleared.
- Reset mid-operation: everything clears immediately, same as the reset state. No stale result is emitted after rstn releases.
- Total latency, empty FIFO, out_ready=1: out_valid rises in the cycle after arrival, LATENCY+1 cycles after acc.
- Zero/denormal semantics belong to the sqrt block. This block passes sq_y unmodified.

Test Plan:
- Single issue x=0x40800000 (4.0), tag=0x15, out_ready=1 -> out_valid=1 at acc+6 cycles, out_data=0x40000000, out_tag=0x15, for one cycle.
- 10 back-to-back issues with tags 0..9, out_ready=0 -> exactly 8 accepted, in_ready=0 from cycle 8. Then set out_ready=1 -> tags 0..7 drain in order, in_ready re-asserts, err_ovf stays 0.
- Random in_valid and out_ready (50%) for 2000 cycles against a scoreboard model of sqrt -> every tag emitted once, in order, with the correct result, err_ovf=0.
- Issue tags 1,2,3 on consecutive cycles, assert flush 2 cycles later -> no outputs ever emitted, in_ready=1 the next cycle. Issue tag 4 -> emitted with the correct result.
- Fill the FIFO to 5 entries, then pull rstn low for 1 cycle mid-stream -> out_valid=0 immediately, in_ready=1 after release, no residual outputs.
- Issue x=0x00000000, tag=0x3F -> out_data=0x00000000, out_tag=0x3F.
